// File: rtl/board_controller.sv
// rtl/board_controller.sv - 4x4 Connect-4 board state and column-drop sequencing
module board_controller (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        new_game,
    input  logic        drop_req,
    input  logic [1:0]  col_sel,
    input  logic [1:0]  game_status,
    output logic [15:0] game_board,
    output logic [15:0] player_cells,
    output logic        current_player,
    output logic        ready,
    output logic        move_err,
    output logic        falling_valid,
    output logic [3:0]  falling_cell,
    output logic        game_over
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FALL,
        S_COMMIT,
        S_CHECK,
        S_OVER
    } state_t;

    state_t     state;
    logic       chk_cnt;
    logic [1:0] fall_row;
    logic [1:0] col;
    logic [3:0] below_idx;
    logic [3:0] cur_idx;
    logic       below_occupied;

    // Row 0 is the top of the board, so indices decrease as the token falls.
    function automatic logic [3:0] cell_idx(input logic [1:0] r, input logic [1:0] c);
        return 4'd12 - {r, 2'b00} + {2'b00, c};
    endfunction

    assign cur_idx        = cell_idx(fall_row, col);
    assign below_idx      = cell_idx(fall_row + 2'd1, col);
    assign below_occupied = game_board[below_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            chk_cnt        <= 1'b0;
            fall_row       <= 2'd0;
            col            <= 2'd0;
            game_board     <= 16'h0000;
            player_cells   <= 16'h0000;
            current_player <= 1'b0;
            ready          <= 1'b1;
            move_err       <= 1'b0;
            falling_valid  <= 1'b0;
            falling_cell   <= 4'd0;
            game_over      <= 1'b0;
        end else if (new_game) begin
            state          <= S_IDLE;
            chk_cnt        <= 1'b0;
            fall_row       <= 2'd0;
            col            <= 2'd0;
            game_board     <= 16'h0000;
            player_cells   <= 16'h0000;
            current_player <= 1'b0;
            ready          <= 1'b1;
            move_err       <= 1'b0;
            falling_valid  <= 1'b0;
            falling_cell   <= 4'd0;
            game_over      <= 1'b0;
        end else begin
            move_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (drop_req) begin
                        if (game_board[4'd12 + {2'b00, col_sel}]) begin
                            move_err <= 1'b1;
                        end else begin
                            col           <= col_sel;
                            fall_row      <= 2'd0;
                            state         <= S_FALL;
                            ready         <= 1'b0;
                            falling_valid <= 1'b1;
                            falling_cell  <= cell_idx(2'd0, col_sel);
                        end
                    end
                end
                S_FALL: begin
                    if (fall_row == 2'd3 || below_occupied) begin
                        state         <= S_COMMIT;
                        falling_valid <= 1'b0;
                        falling_cell  <= 4'd0;
                    end else begin
                        fall_row     <= fall_row + 2'd1;
                        falling_cell <= below_idx;
                    end
                end
                S_COMMIT: begin
                    game_board[cur_idx]   <= 1'b1;
                    player_cells[cur_idx] <= current_player;
                    chk_cnt               <= 1'b0;
                    state                 <= S_CHECK;
                end
                S_CHECK: begin
                    // Second cycle gives the detector's registered status time to see the new cell.
                    if (!chk_cnt) begin
                        chk_cnt <= 1'b1;
                    end else if (game_status == 2'b00) begin
                        current_player <= ~current_player;
                        ready          <= 1'b1;
                        state          <= S_IDLE;
                    end else begin
                        game_over <= 1'b1;
                        state     <= S_OVER;
                    end
                end
                S_OVER: begin
                    if (drop_req) begin
                        move_err <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
